// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared pipeline constants, MDU state encoding and priority helper
// Contents:
//   STG_IF..STG_WB     stage indices used for the stall/flush bit positions
//   MUL/DIV_CYCLES_DEF default multiply/divide EX latencies
//   MDU_CNT_W          width of the MDU latency counter (latencies up to 63)
//   mdu_state_e        MDU timing FSM states
//   onehot_hi()        keeps only the highest-index set bit of a request vector
package mips_pkg;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;
  localparam int NUM_STG = 5;

  localparam int MUL_CYCLES_DEF = 4;
  localparam int DIV_CYCLES_DEF = 32;
  localparam int MDU_CNT_W      = 6;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  // A stall or flush at a later stage already covers every earlier stage,
  // so only the deepest request needs to reach the pipeline.
  function automatic logic [NUM_STG-1:0] onehot_hi(input logic [NUM_STG-1:0] req);
    logic [NUM_STG-1:0] sel;
    sel = '0;
    for (int i = 0; i < NUM_STG; i++) begin
      if (req[i]) begin
        sel    = '0;
        sel[i] = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/mdu_timer.sv
// rtl/mdu_timer.sv - multiply/divide EX-latency timer (IDLE/BUSY/DONE)
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   start      EX holds a mult/div instruction
//   is_div     1 = divide latency, 0 = multiply latency
//   freeze     a later stage is stalled; counter and state hold
//   stall_ex   EX must hold this cycle
//   busy       FSM is counting down
//   done       one-cycle completion pulse
module mdu_timer
  import mips_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic is_div,
  input  logic freeze,
  output logic stall_ex,
  output logic busy,
  output logic done
);

  // The start cycle in IDLE is itself one hold cycle, so BUSY counts one less.
  localparam logic [MDU_CNT_W-1:0] MUL_LOAD = MDU_CNT_W'(MUL_CYCLES - 1);
  localparam logic [MDU_CNT_W-1:0] DIV_LOAD = MDU_CNT_W'(DIV_CYCLES - 1);

  mdu_state_e           state, state_next;
  logic [MDU_CNT_W-1:0] count, count_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= MDU_IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    stall_ex   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      MDU_IDLE: begin
        if (start) begin
          stall_ex = 1'b1;
          if (!freeze) begin
            count_next = is_div ? DIV_LOAD : MUL_LOAD;
            state_next = MDU_BUSY;
          end
        end
      end
      MDU_BUSY: begin
        stall_ex = 1'b1;
        busy     = 1'b1;
        if (!freeze) begin
          count_next = count - 1'b1;
          if (count == MDU_CNT_W'(1)) state_next = MDU_DONE;
        end
      end
      MDU_DONE: begin
        // start is ignored here: the finished instruction is still in EX
        // this cycle and must not retrigger. The pulse is emitted on the
        // cycle the FSM actually leaves DONE.
        if (!freeze) begin
          done       = 1'b1;
          state_next = MDU_IDLE;
        end
      end
      default: begin
        state_next = MDU_IDLE;
        count_next = '0;
      end
    endcase
  end

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline hazard detection and stall/flush priority
// Build option: HAZARD_FORWARD_EN (defined: only EX loads cause data stalls;
//   undefined: any EX or MEM register writer causes a data stall).
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   id_rs, id_rt, id_uses_rs/rt  ID source registers and their use flags
//   id_jump                      jump decoded in ID
//   ex_rd, ex_regwrite, ex_memread, ex_branch_taken, ex_mdu, ex_div
//                                EX destination / writer / load / branch / MDU op
//   mem_rd, mem_regwrite         MEM destination / writer
//   mem_req, mem_ack             data-memory handshake
//   stall, flush                 one-hot per-stage requests (bit0 IF .. bit4 WB)
//   mdu_busy, mdu_done           MDU timing status
module hazard_unit
  import mips_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [4:0]   id_rs,
  input  logic [4:0]   id_rt,
  input  logic         id_uses_rs,
  input  logic         id_uses_rt,
  input  logic         id_jump,
  input  logic [4:0]   ex_rd,
  input  logic         ex_regwrite,
  input  logic         ex_memread,
  input  logic         ex_branch_taken,
  input  logic         ex_mdu,
  input  logic         ex_div,
  input  logic [4:0]   mem_rd,
  input  logic         mem_regwrite,
  input  logic         mem_req,
  input  logic         mem_ack,
  output logic [4:0]   stall,
  output logic [4:0]   flush,
  output logic         mdu_busy,
  output logic         mdu_done
);

  logic writer_ex;
  logic writer_mem;

`ifdef HAZARD_FORWARD_EN
  // Forwarding covers everything except a load whose data is not yet back.
  assign writer_ex  = ex_regwrite & ex_memread;
  assign writer_mem = 1'b0;
  logic unused_mem;
  assign unused_mem = ^{mem_rd, mem_regwrite};
`else
  assign writer_ex  = ex_regwrite;
  assign writer_mem = mem_regwrite;
  logic unused_memread;
  assign unused_memread = ex_memread;
`endif

  logic rs_hazard;
  logic rt_hazard;
  logic data_hazard;

  assign rs_hazard = id_uses_rs && (id_rs != 5'd0) &&
                     ((writer_ex && (id_rs == ex_rd)) || (writer_mem && (id_rs == mem_rd)));
  assign rt_hazard = id_uses_rt && (id_rt != 5'd0) &&
                     ((writer_ex && (id_rt == ex_rd)) || (writer_mem && (id_rt == mem_rd)));
  assign data_hazard = rs_hazard | rt_hazard;

  logic mem_wait;
  logic wb_stall;
  logic mdu_stall;
  logic freeze;

  assign mem_wait = mem_req & ~mem_ack;
  // No WB-stage stall source exists in this pipeline; kept so the MDU freeze
  // and priority logic read the same way for every stage.
  assign wb_stall = 1'b0;
  assign freeze   = mem_wait | wb_stall;

  mdu_timer #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_mdu_timer (
    .clk      (clk),
    .rst      (rst),
    .start    (ex_mdu),
    .is_div   (ex_div),
    .freeze   (freeze),
    .stall_ex (mdu_stall),
    .busy     (mdu_busy),
    .done     (mdu_done)
  );

  logic       late_stall;
  logic [4:0] flush_req;
  logic [4:0] stall_req;
  logic       id_stall;

  // While EX or later is held, the branch/jump is still in place and will be
  // re-evaluated once the hold clears, so no flush is issued now.
  assign late_stall = mdu_stall | mem_wait | wb_stall;

  always_comb begin
    flush_req              = '0;
    flush_req[STG_ID]      = ex_branch_taken;
    flush_req[STG_IF]      = id_jump & ~ex_branch_taken;
    if (late_stall) flush_req = '0;
  end

  // An instruction being squashed does not need to wait for its operands.
  assign id_stall = data_hazard & ~(|flush_req);

  always_comb begin
    stall_req          = '0;
    stall_req[STG_ID]  = id_stall;
    stall_req[STG_EX]  = mdu_stall;
    stall_req[STG_MEM] = mem_wait;
    stall_req[STG_WB]  = wb_stall;
  end

  assign stall = onehot_hi(stall_req);
  assign flush = onehot_hi(flush_req);

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameters: MUL_CYCLES, default 4, multiply EX latency in cycles; DIV_CYCLES, default 32, divide EX latency in cycles (both 2..63).
REQ-002 SHALL have ports, clock and reset first; reset rst, asynchronous, active-low; clock clk:
  clk  in  1  clock
  rst  in  1  asynchronous active-low reset
  id_rs, id_rt  in  5 each  ID source registers
  id_uses_rs, id_uses_rt  in  1 each  ID reads the register
  id_jump  in  1  jump decoded in ID
  ex_rd  in  5  EX destination register
  ex_regwrite, ex_memread  in  1 each  EX writes a register / is a load
  ex_branch_taken  in  1  branch resolved taken in EX
  ex_mdu, ex_div  in  1 each  EX holds mult/div; 1=divide
  mem_rd  in  5  MEM destination register
  mem_regwrite  in  1  MEM writes a register
  mem_req, mem_ack  in  1 each  data-memory request/acknowledge
  stall  out  5  per-stage stall request (bit0 IF .. bit4 WB)
  flush  out  5  per-stage flush request
  mdu_busy, mdu_done  out  1 each  MDU timing busy / completion pulse

Function
REQ-003 stall[k] SHALL mean stages 0..k hold and a bubble enters k+1; flush[k] SHALL mean stages 0..k are squashed.
REQ-004 stall and flush SHALL each be one-hot or zero; highest-index active request wins.
REQ-005 Memory wait: mem_req && !mem_ack SHALL assert stall[3] combinationally in that cycle.
REQ-006 MDU FSM states SHALL be IDLE, BUSY, DONE.
REQ-007 IDLE with ex_mdu=1 SHALL load counter with (ex_div ? DIV_CYCLES : MUL_CYCLES)-1, go BUSY, assert stall[2] that cycle.
REQ-008 BUSY SHALL decrement counter, assert stall[2] and mdu_busy; when counter==1 it SHALL go DONE (total EX hold = latency cycles).
REQ-009 DONE SHALL deassert stall[2], pulse mdu_done for one cycle, ignore ex_mdu, return to IDLE.
REQ-010 MDU counter SHALL freeze and FSM hold state while stall[3] or stall[4] is active.
REQ-011 Data hazard: ID source r (used, r!=0) matching a writer SHALL assert stall[1]; register 0 SHALL never hazard.
REQ-012 ex_branch_taken SHALL assert flush[1]; id_jump (without taken branch) SHALL assert flush[0].
REQ-013 Any branch/jump flush SHALL be suppressed while stall[k], k>=2, is active; instruction re-evaluates next cycle.
REQ-014 Flush and stall[1] simultaneous: flush SHALL be asserted and stall[1] suppressed (squashed instruction needs no stall).
REQ-015 Outputs other than mdu_done/mdu_busy SHALL be combinational from inputs and FSM state; no extra latency.

Reset
REQ-016 rst low SHALL force FSM IDLE, counter 0, mdu_busy=0, mdu_done=0 immediately, aborting any MDU operation.
REQ-017 During and after reset, stall and flush SHALL be driven purely by inputs and IDLE state.

Configuration
REQ-018 Macro HAZARD_FORWARD_EN defined: REQ-011 writers SHALL be only EX loads (ex_regwrite && ex_memread, load-use, one-cycle stall).
REQ-019 HAZARD_FORWARD_EN undefined: writers SHALL be any EX (ex_regwrite) or MEM (mem_regwrite) instruction.

Structure
REQ-020 Shared package mips_pkg SHALL hold stage index constants (IF=0..WB=4), MDU state encoding and default MUL/DIV latencies.
REQ-021 MDU FSM and counter SHALL be sub-module mdu_timer; hazard_unit SHALL contain detection and priority logic.

Verification
REQ-022 ex_regwrite=1, ex_memread=1, ex_rd=5, id_rs=5, id_uses_rs=1 -> stall=00010 one cycle (both configs).
REQ-023 ex_mdu=1, ex_div=0 held -> stall=00100 for 4 cycles, then mdu_done=1 with stall=00000, next cycle IDLE.
REQ-024 Divide in progress plus mem_req=1, mem_ack=0 for 3 cycles -> stall=01000, total stall[2] cycles = 32+3.
REQ-025 ex_branch_taken=1 with mem stall active -> flush=00000, stall=01000; after mem_ack -> flush=00010.
REQ-026 rst low mid-divide (counter=10) -> mdu_busy=0 immediately, FSM IDLE, stall=00000 with idle inputs.
REQ-027 HAZARD_FORWARD_EN undefined, mem_regwrite=1, mem_rd=7, id_rt=7, id_uses_rt=1 -> stall=00010; defined -> stall=00000.
